// File: rtl/wrap_count_extender.sv
// Widens a narrow wrapping count into a monotonic {epoch, sample} value.
// Roll-overs bump the epoch; flags mark wraps, odd steps and epoch overflow.
module wrap_count_extender #(
  parameter int IN_W     = 4,
  parameter int EPOCH_W  = 8,
  parameter int MAX_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_count,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IN_W+EPOCH_W-1:0] out_count,
  output logic                    wrap_pulse,
  output logic                    step_err,
  output logic                    epoch_ovf
);

  localparam logic [IN_W-1:0] MAX_STEP_W = IN_W'(MAX_STEP);

  typedef enum logic {UNSYNC, TRACK} state_e;

  state_e                    state_q;
  logic [EPOCH_W-1:0]        epoch_q;
  logic [EPOCH_W-1:0]        epoch_d;
  logic [IN_W-1:0]           prev_q;
  logic [IN_W-1:0]           delta;
  logic                      out_valid_q;
  logic [IN_W+EPOCH_W-1:0]   out_count_q;
  logic                      wrap_q;
  logic                      err_q;
  logic                      ovf_q;
  logic                      accept;
  logic                      wrap_d;
  logic                      err_d;

  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    accept  = in_valid && in_ready;
    delta   = in_count - prev_q;
    // The first sample after reset has no predecessor, so no wrap or step is inferred.
    wrap_d  = (state_q == TRACK) && (in_count < prev_q);
    err_d   = (state_q == TRACK) && ((delta == '0) || (delta > MAX_STEP_W));
    epoch_d = wrap_d ? epoch_q + EPOCH_W'(1) : epoch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNSYNC;
      epoch_q     <= '0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (accept) begin
      state_q     <= TRACK;
      prev_q      <= in_count;
      epoch_q     <= epoch_d;
      if (wrap_d && (&epoch_q)) ovf_q <= 1'b1;
      out_valid_q <= 1'b1;
      out_count_q <= {epoch_d, in_count};
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end else if (out_ready) begin
      // Beat consumed with nothing to replace it; flags drop with out_valid.
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign wrap_pulse = wrap_q;
  assign step_err   = err_q;
  assign epoch_ovf  = ovf_q;

endmodule

// File: tb/tb_wrap_count_extender.sv
// Directed bench for wrap_count_extender: default instance plus a 2-bit-epoch
// instance sharing the same stimulus for the overflow scenario.
module tb_wrap_count_extender;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_count;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, wrap_a, err_a, ovf_a;
  logic [11:0] count_a;
  logic        in_ready_b, out_valid_b, wrap_b, err_b, ovf_b;
  logic [5:0]  count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wrap_count_extender #(.IN_W(4), .EPOCH_W(8), .MAX_STEP(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_count(in_count), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_count(count_a), .wrap_pulse(wrap_a), .step_err(err_a), .epoch_ovf(ovf_a)
  );

  wrap_count_extender #(.IN_W(4), .EPOCH_W(2), .MAX_STEP(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_count(in_count), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_count(count_b), .wrap_pulse(wrap_b), .step_err(err_b), .epoch_ovf(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; in_count = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid_a !== 1'b0 || count_a !== 12'd0 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: valid=%b count=%0d ready=%b required 0/0/1", out_valid_a, count_a, in_ready_a);
    end
    checks++;
    if (wrap_a !== 1'b0 || err_a !== 1'b0 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags_a: wrap=%b err=%b ovf=%b required 0/0/0", wrap_a, err_a, ovf_a);
    end
    tick();
    checks++;
    if (out_valid_b !== 1'b0 || count_b !== 6'd0 || ovf_b !== 1'b0 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_b: valid=%b count=%0d ovf=%b ready=%b required 0/0/0/1", out_valid_b, count_b, ovf_b, in_ready_b);
    end
  endtask

  task automatic test_monotonic_wrap();
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_count = 4'(i);
      tick();
      checks++;
      if (out_valid_a !== 1'b1 || count_a !== 12'(i)) begin
        errors++;
        $display("FAIL mono_count beat %0d: valid=%b count=%0d required 1/%0d", i, out_valid_a, count_a, i);
      end
      checks++;
      if (wrap_a !== (i == 16) || err_a !== 1'b0) begin
        errors++;
        $display("FAIL mono_flags beat %0d: wrap=%b err=%b required %b/0", i, wrap_a, err_a, (i == 16));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || wrap_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL mono_drain: valid=%b wrap=%b err=%b required 0/0/0", out_valid_a, wrap_a, err_a);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    in_valid = 1'b1; in_count = 4'd14;
    tick();
    checks++;
    if (count_a !== 12'd14 || out_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: count=%0d valid=%b required 14/1", count_a, out_valid_a);
    end
    in_count = 4'd15;
    tick();
    out_ready = 1'b0;
    in_count  = 4'd0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (count_a !== 12'd15 || out_valid_a !== 1'b1 || in_ready_a !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold %0d: count=%0d valid=%b ready=%b required 15/1/0", k, count_a, out_valid_a, in_ready_a);
      end
      tick();
    end
    checks++;
    if (count_a !== 12'd15 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold_end: count=%0d wrap=%b required 15/0", count_a, wrap_a);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (count_a !== 12'd16 || wrap_a !== 1'b1 || err_a !== 1'b0 || out_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: count=%0d wrap=%b err=%b valid=%b required 16/1/0/1", count_a, wrap_a, err_a, out_valid_a);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_step_anomaly();
    logic [3:0]  seq  [4] = '{4'd3, 4'd7, 4'd7, 4'd2};
    logic [11:0] expc [4] = '{12'd3, 12'd7, 12'd7, 12'd18};
    logic        expw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        expe [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_count = seq[i];
      tick();
      checks++;
      if (count_a !== expc[i] || wrap_a !== expw[i] || err_a !== expe[i]) begin
        errors++;
        $display("FAIL step beat %0d: count=%0d wrap=%b err=%b required %0d/%b/%b", i, count_a, wrap_a, err_a, expc[i], expw[i], expe[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_epoch_overflow();
    apply_reset();
    for (int k = 0; k < 67; k++) begin
      in_valid = 1'b1;
      in_count = 4'(k);
      tick();
      checks++;
      if (count_b !== 6'(k) || ovf_b !== (k >= 64)) begin
        errors++;
        $display("FAIL ovf beat %0d: count=%0d ovf=%b required %0d/%b", k, count_b, ovf_b, k % 64, (k >= 64));
      end
      if (k == 64) begin
        checks++;
        if (wrap_b !== 1'b1 || ovf_a !== 1'b0) begin
          errors++;
          $display("FAIL ovf_wrap: wrap_b=%b ovf_a=%b required 1/0", wrap_b, ovf_a);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (ovf_b !== 1'b1 || out_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b valid=%b required 1/0", ovf_b, out_valid_b);
    end
  endtask

  task automatic test_reset_mid_operation();
    logic [3:0] seq [6] = '{4'd15, 4'd0, 4'd15, 4'd0, 4'd15, 4'd0};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_count = seq[i];
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    checks++;
    if (count_a !== 12'd48 || out_valid_a !== 1'b1 || wrap_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_held: count=%0d valid=%b wrap=%b required 48/1/1", count_a, out_valid_a, wrap_a);
    end
    rst = 1'b1; in_valid = 1'b1; in_count = 4'd5;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid_a !== 1'b0 || ovf_a !== 1'b0 || ovf_b !== 1'b0 || count_a !== 12'd0 || wrap_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ovf_a=%b ovf_b=%b count=%0d wrap=%b required 0/0/0/0/0", out_valid_a, ovf_a, ovf_b, count_a, wrap_a);
    end
    in_valid = 1'b1; in_count = 4'd9;
    tick();
    checks++;
    if (count_a !== 12'd9 || wrap_a !== 1'b0 || err_a !== 1'b0 || out_valid_a !== 1'b1 || count_b !== 6'd9) begin
      errors++;
      $display("FAIL mid_resync: count=%0d wrap=%b err=%b valid=%b count_b=%0d required 9/0/0/1/9", count_a, wrap_a, err_a, out_valid_a, count_b);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_count = '0; out_ready = 1'b1;
    test_reset();
    test_monotonic_wrap();
    test_backpressure();
    test_step_anomaly();
    test_epoch_overflow();
    test_reset_mid_operation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
